// File: rtl/multicycle_controller_pkg.sv
// Shared ISA codes, PCSrc encodings and controller state encoding for the multicycle controller.
package multicycle_controller_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned FUNC_W  = 3;
    localparam int unsigned PCSRC_W = 2;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE  = 4'd0;
    localparam logic [OP_W-1:0] OP_JCLASS = 4'd1;
    localparam logic [OP_W-1:0] OP_ANDI   = 4'd2;
    localparam logic [OP_W-1:0] OP_ADDI   = 4'd3;
    localparam logic [OP_W-1:0] OP_LW     = 4'd4;
    localparam logic [OP_W-1:0] OP_SW     = 4'd5;
    localparam logic [OP_W-1:0] OP_BEQ    = 4'd6;
    localparam logic [OP_W-1:0] OP_BNE    = 4'd7;
    localparam logic [OP_W-1:0] OP_FOR    = 4'd8;
    localparam logic [OP_W-1:0] OP_HALT   = 4'd15;

    localparam logic [FUNC_W-1:0] FN_JMP  = 3'd0;
    localparam logic [FUNC_W-1:0] FN_CALL = 3'd1;
    localparam logic [FUNC_W-1:0] FN_RET  = 3'd2;

    localparam logic [PCSRC_W-1:0] PCSRC_INC    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [PCSRC_W-1:0] PCSRC_RR     = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_LOOP   = 4'd8,
        S_HALT   = 4'd9,
        S_ERROR  = 4'd10
    } state_t;

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts cycles spent waiting on data memory; flags the last permitted wait cycle.
module multicycle_controller_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired_c = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback and decodes
// datapath strobes straight from the state register and the latched IR fields.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNC_W-1:0]    func,
    input  logic                 zero,
    input  logic                 bus_b_nz,
    input  logic                 mem_ready,
    output logic                 IRWr,
    output logic                 PCWr,
    output logic [PCSRC_W-1:0]   PCSrc,
    output logic                 LoopTake,
    output logic                 RRWr,
    output logic                 RegDst,
    output logic                 RegWr,
    output logic                 ExtOp,
    output logic                 ALUSrc,
    output logic                 ForSel,
    output logic                 MemRd,
    output logic                 MemWr,
    output logic                 WBdata,
    output logic                 halted,
    output logic                 err,
    output logic [STATE_W-1:0]   state
);

    state_t state_q;
    state_t state_d;
    logic   timer_clear;
    logic   timer_en;
    logic   timer_expired;

    multicycle_controller_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (timer_clear),
        .enable    (timer_en),
        .expired_c (timer_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Strobes are forced low while RST is held so a reset mid-access kills them at once.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        IRWr        = 1'b0;
        PCWr        = 1'b0;
        PCSrc       = PCSRC_INC;
        LoopTake    = 1'b0;
        RRWr        = 1'b0;
        RegDst      = 1'b0;
        RegWr       = 1'b0;
        ExtOp       = 1'b0;
        ALUSrc      = 1'b0;
        ForSel      = 1'b0;
        MemRd       = 1'b0;
        MemWr       = 1'b0;
        WBdata      = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    IRWr    = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (Op)
                        OP_HALT:                                     state_d = S_HALT;
                        OP_JCLASS:                                   state_d = S_JUMP;
                        OP_BEQ, OP_BNE:                              state_d = S_BRANCH;
                        OP_FOR:                                      state_d = S_LOOP;
                        OP_RTYPE, OP_ANDI, OP_ADDI, OP_LW, OP_SW:    state_d = S_EXEC;
                        default:                                     state_d = S_ERROR;
                    endcase
                end
                S_EXEC: begin
                    ALUSrc = (Op != OP_RTYPE);
                    ExtOp  = (Op != OP_ANDI);
                    if (Op == OP_LW) begin
                        state_d = S_MEM_RD;
                    end else if (Op == OP_SW) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM_RD: begin
                    MemRd       = 1'b1;
                    ALUSrc      = 1'b1;
                    ExtOp       = 1'b1;
                    timer_clear = 1'b0;
                    if (mem_ready) begin
                        state_d = S_WB;
                    end else if (timer_expired) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                S_MEM_WR: begin
                    MemWr       = 1'b1;
                    ALUSrc      = 1'b1;
                    ExtOp       = 1'b1;
                    timer_clear = 1'b0;
                    if (mem_ready) begin
                        PCWr    = 1'b1;
                        state_d = S_FETCH;
                    end else if (timer_expired) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                S_WB: begin
                    RegWr   = 1'b1;
                    RegDst  = (Op == OP_RTYPE);
                    WBdata  = (Op == OP_LW);
                    PCWr    = 1'b1;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    PCWr = 1'b1;
                    if (((Op == OP_BEQ) && zero) || ((Op == OP_BNE) && !zero)) begin
                        PCSrc = PCSRC_BRANCH;
                    end
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    state_d = S_FETCH;
                    case (func)
                        FN_JMP: begin
                            PCWr  = 1'b1;
                            PCSrc = PCSRC_JUMP;
                        end
                        FN_CALL: begin
                            PCWr  = 1'b1;
                            PCSrc = PCSRC_JUMP;
                            RRWr  = 1'b1;
                        end
                        FN_RET: begin
                            PCWr  = 1'b1;
                            PCSrc = PCSRC_RR;
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_LOOP: begin
                    ForSel = 1'b1;
                    PCWr   = 1'b1;
                    if (bus_b_nz) begin
                        RegWr    = 1'b1;
                        LoopTake = 1'b1;
                    end
                    state_d = S_FETCH;
                end
                S_HALT:  halted  = 1'b1;
                S_ERROR: err     = 1'b1;
                default: state_d = S_ERROR;
            endcase
        end
    end

endmodule
